gpio_seq_ctrl: RTL
==================

Name: gpio_seq_ctrl

Overview:
Autonomous pattern sequencer for the 32-bit GPIO output register. Software loads up to DEPTH output words and an inter-step delay over a Wishbone slave port. It then sets EN, and the block replays the words through its own Wishbone master port into the GPIO block's RGPIO_OUT register, once or in a loop. It sits between the CPU bus fabric and the GPIO slave, and offloads bit-banged waveforms from the core.

Parameters:
DEPTH, 8, pattern table entries (power of 2, 2..16)
OUT_ADR, 4'h4, master address of the GPIO RGPIO_OUT register
aw, 6, slave address width

Ports:
wb_clk_i  in  1  clock
wb_rst_i  in  1  reset, asynchronous, active-high
wb_cyc_i  in  1  slave cycle valid
wb_stb_i  in  1  slave strobe
wb_we_i  in  1  slave write enable
wb_adr_i  in  aw  slave byte address; word index = wb_adr_i[5:2]
wb_dat_i  in  32  slave write data
wb_sel_i  in  4  slave byte selects
wb_dat_o  out  32  slave read data
wb_ack_o  out  1  slave ack
wb_err_o  out  1  slave error, tied 0
irq_o  out  1  done/error interrupt
m_cyc_o  out  1  master cycle
m_stb_o  out  1  master strobe
m_we_o  out  1  master write, constant 1
m_adr_o  out  4  master address, constant OUT_ADR
m_sel_o  out  4  master byte selects, constant 4'hF
m_dat_o  out  32  master write data
m_ack_i  in  1  master ack
m_err_i  in  1  master error

Behaviour:
- Slave ack is combinational: wb_ack_o = wb_cyc_i & wb_stb_i. Zero wait states.
- Writes are gated by wb_sel_i per byte. Reads of unmapped words return 0.
- Register map (word index):
  - 0 CTRL RW: [0] EN, [1] LOOP, [2] IE, [7:4] LAST (index of the final entry; upper bits beyond log2(DEPTH) ignored).
  - 1 STATUS RO: [0] BUSY, [1] DONE, [2] ERR, [7:4] IDX.
  - 2 DELAY RW: [15:0], upper bits read 0.
  - 3 reserved.
  - 4..4+DEPTH-1 TABLE RW: one 32-bit entry each.
- Reset: all registers, table, IDX, counter and flags 0. FSM IDLE. m_cyc_o, m_stb_o, m_dat_o = 0. irq_o = 0.
- FSM states:
  - IDLE: BUSY=0. A CTRL write with EN=1 gives IDX=0, DONE=0, ERR=0, next state WRITE.
  - WRITE: m_cyc_o = m_stb_o = 1. m_dat_o = TABLE[IDX], latched on entry. Held until m_ack_i or m_err_i is sampled high.
    - On ack: next state HOLD, counter = DELAY.
    - On err: ERR=1, EN=0, next state IDLE.
  - HOLD: master idle. Counter decrements each cycle.
    - At count 0 with EN=0: next state IDLE.
    - At count 0, IDX≠LAST: IDX+1, next state WRITE.
    - At count 0, IDX==LAST with LOOP=1: IDX=0, next state WRITE.
    - At count 0, IDX==LAST with LOOP=0: DONE=1, EN cleared by hardware, next state IDLE.
- Timing: ack sampled at cycle k gives stb reasserted at cycle k+DELAY+2. With DELAY=0 there is one idle cycle between steps.
- Abort: software writes EN=0.
  - In WRITE, the bus cycle is never dropped early; it completes, then the FSM goes to IDLE with DONE unchanged.
  - In HOLD, the FSM goes to IDLE at the next cycle.
- A CTRL write with EN=1 while BUSY updates LOOP/IE/LAST but does not restart.
- LAST and LOOP changes while busy take effect at the next HOLD-end decision.
- TABLE writes while busy are allowed; an entry is sampled at WRITE entry.
- If hardware clears EN and a CTRL write lands in the same cycle, the software write wins.
- irq_o = IE & (DONE | ERR), combinational from the registers. Cleared by the next start.
- Reset asserted mid-operation: master signals drop to 0 immediately (asynchronous).

Decomposition:
- Package gpio_seq_pkg:
  - State enum: IDLE, WRITE, HOLD.
  - Register word-index constants: CTRL=0, STATUS=1, DELAY=2, TABLE_BASE=4.
  - CTRL/STATUS bit-position constants.
- No sub-module. Table is a flop array inside the block.

Test Plan:
- DEPTH=8, TABLE[0..3] = 1, 2, 4, 8; LAST=3; DELAY=2; LOOP=0; ack tied to stb&cyc; EN written -> four master writes 1, 2, 4, 8; stb rising edges 4 cycles apart; then DONE=1, EN=0, BUSY=0, irq_o=1 when IE=1.
- LOOP=1, LAST=1, TABLE = A5A5A5A5, 5A5A5A5A, DELAY=0 -> writes alternate A5A5A5A5 / 5A5A5A5A with one idle cycle between; after 6 writes, write EN=0 -> stops at IDLE, DONE=0.
- Slave holds m_ack_i low for 5 cycles, software clears EN meanwhile -> m_stb_o stays high until ack, then IDLE; no further writes.
- m_err_i on the second step -> ERR=1, EN=0, IDX=1, irq_o=1 with IE=1; no third write.
- TABLE[2] rewritten to DEADBEEF while the sequence is in HOLD after step 1 -> step 2 writes DEADBEEF. Byte write sel=4'b0010 of 0x0000AB00 to DELAY -> DELAY[15:8]=AB, rest unchanged.
- Reset pulse during WRITE -> m_cyc_o/m_stb_o go low the same cycle; all registers and STATUS read 0 afterward.

Source files
------------

// File: rtl/gpio_seq_pkg.sv
// rtl/gpio_seq_pkg.sv - shared types, register map and helpers for the GPIO pattern sequencer
package gpio_seq_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WRITE = 2'd1,
      HOLD  = 2'd2
   } seq_state_t;

   // Slave register word indices
   localparam int REG_CTRL       = 0;
   localparam int REG_STATUS     = 1;
   localparam int REG_DELAY      = 2;
   localparam int REG_TABLE_BASE = 4;

   // CTRL bit positions
   localparam int CTRL_EN       = 0;
   localparam int CTRL_LOOP     = 1;
   localparam int CTRL_IE       = 2;
   localparam int CTRL_LAST_LSB = 4;

   // STATUS bit positions
   localparam int STAT_BUSY    = 0;
   localparam int STAT_DONE    = 1;
   localparam int STAT_ERR     = 2;
   localparam int STAT_IDX_LSB = 4;

   // Merge a bus write into an existing word, one byte lane per select bit
   function automatic logic [31:0] byte_merge(input logic [31:0] old_v,
                                              input logic [31:0] new_v,
                                              input logic [3:0]  sel);
      logic [31:0] r;
      for (int b = 0; b < 4; b++) begin
         r[8*b +: 8] = sel[b] ? new_v[8*b +: 8] : old_v[8*b +: 8];
      end
      return r;
   endfunction

endpackage

// File: rtl/gpio_seq_ctrl.sv
// rtl/gpio_seq_ctrl.sv - Wishbone-programmed pattern sequencer driving the GPIO output register
module gpio_seq_ctrl
   import gpio_seq_pkg::*;
#(
   parameter int         DEPTH   = 8,
   parameter logic [3:0] OUT_ADR = 4'h4,
   parameter int         aw      = 6
) (
   input  logic          wb_clk_i,
   input  logic          wb_rst_i,
   input  logic          wb_cyc_i,
   input  logic          wb_stb_i,
   input  logic          wb_we_i,
   input  logic [aw-1:0] wb_adr_i,
   input  logic [31:0]   wb_dat_i,
   input  logic [3:0]    wb_sel_i,
   output logic [31:0]   wb_dat_o,
   output logic          wb_ack_o,
   output logic          wb_err_o,
   output logic          irq_o,
   output logic          m_cyc_o,
   output logic          m_stb_o,
   output logic          m_we_o,
   output logic [3:0]    m_adr_o,
   output logic [3:0]    m_sel_o,
   output logic [31:0]   m_dat_o,
   input  logic          m_ack_i,
   input  logic          m_err_i
);

   localparam int IW  = $clog2(DEPTH);
   localparam int WIW = aw - 2;

   logic [WIW-1:0] word_idx;
   logic           wr_en;
   logic           ctrl_wr;
   logic           delay_wr;
   logic           tbl_hit;
   logic [IW-1:0]  tbl_sel;
   logic [31:0]    ctrl_rd;
   logic [31:0]    status_rd;
   logic [31:0]    ctrl_wval;
   logic [31:0]    delay_wval;

   logic           ctrl_en;
   logic           ctrl_loop;
   logic           ctrl_ie;
   logic [IW-1:0]  ctrl_last;
   logic [15:0]    delay_q;
   logic [31:0]    tbl [DEPTH];

   seq_state_t     state;
   logic [IW-1:0]  idx;
   logic [IW-1:0]  idx_nxt;
   logic           done_q;
   logic           err_q;
   logic [15:0]    cnt;

   logic           start;
   logic           hold_end;
   logic           final_step;
   logic           hw_clr_en;
   logic           unused_adr;

   assign word_idx   = wb_adr_i[aw-1:2];
   assign unused_adr = &{1'b0, wb_adr_i[1:0]};

   assign wb_ack_o = wb_cyc_i & wb_stb_i;
   assign wb_err_o = 1'b0;
   assign wr_en    = wb_ack_o & wb_we_i;

   assign tbl_hit  = (word_idx >= WIW'(REG_TABLE_BASE)) &&
                     (word_idx <  WIW'(REG_TABLE_BASE + DEPTH));
   assign tbl_sel  = IW'(word_idx - WIW'(REG_TABLE_BASE));
   assign ctrl_wr  = wr_en & (word_idx == WIW'(REG_CTRL));
   assign delay_wr = wr_en & (word_idx == WIW'(REG_DELAY));

   assign ctrl_wval  = byte_merge(ctrl_rd, wb_dat_i, wb_sel_i);
   assign delay_wval = byte_merge({16'h0000, delay_q}, wb_dat_i, wb_sel_i);

   // A restart only happens from IDLE; EN=1 writes while busy just update the fields
   assign start      = ctrl_wr & ctrl_wval[CTRL_EN] & (state == IDLE);
   assign idx_nxt    = idx + IW'(1);
   assign hold_end   = (state == HOLD) & ctrl_en & (cnt == 16'd0);
   assign final_step = (idx == ctrl_last) & ~ctrl_loop;
   assign hw_clr_en  = ((state == WRITE) & m_err_i) | (hold_end & final_step);

   assign irq_o   = ctrl_ie & (done_q | err_q);
   assign m_we_o  = 1'b1;
   assign m_adr_o = OUT_ADR;
   assign m_sel_o = 4'hF;

   // Assemble CTRL and STATUS read images from the stored fields
   always_comb begin
      ctrl_rd                           = '0;
      ctrl_rd[CTRL_EN]                  = ctrl_en;
      ctrl_rd[CTRL_LOOP]                = ctrl_loop;
      ctrl_rd[CTRL_IE]                  = ctrl_ie;
      ctrl_rd[CTRL_LAST_LSB +: IW]      = ctrl_last;
      status_rd                         = '0;
      status_rd[STAT_BUSY]              = (state != IDLE);
      status_rd[STAT_DONE]              = done_q;
      status_rd[STAT_ERR]               = err_q;
      status_rd[STAT_IDX_LSB +: IW]     = idx;
   end

   // Slave read mux; reserved and unmapped words read as zero
   always_comb begin
      wb_dat_o = '0;
      if (tbl_hit) begin
         wb_dat_o = tbl[tbl_sel];
      end else begin
         case (word_idx)
            WIW'(REG_CTRL):   wb_dat_o = ctrl_rd;
            WIW'(REG_STATUS): wb_dat_o = status_rd;
            WIW'(REG_DELAY):  wb_dat_o = {16'h0000, delay_q};
            default:          wb_dat_o = '0;
         endcase
      end
   end

   // Software-visible registers; a software CTRL write beats a same-cycle hardware EN clear
   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         ctrl_en   <= 1'b0;
         ctrl_loop <= 1'b0;
         ctrl_ie   <= 1'b0;
         ctrl_last <= '0;
         delay_q   <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            tbl[i] <= '0;
         end
      end else begin
         if (ctrl_wr) begin
            ctrl_en   <= ctrl_wval[CTRL_EN];
            ctrl_loop <= ctrl_wval[CTRL_LOOP];
            ctrl_ie   <= ctrl_wval[CTRL_IE];
            ctrl_last <= ctrl_wval[CTRL_LAST_LSB +: IW];
         end else if (hw_clr_en) begin
            ctrl_en <= 1'b0;
         end
         if (delay_wr) begin
            delay_q <= delay_wval[15:0];
         end
         if (wr_en & tbl_hit) begin
            tbl[tbl_sel] <= byte_merge(tbl[tbl_sel], wb_dat_i, wb_sel_i);
         end
      end
   end

   // Sequencer: issue one master write per entry, then wait DELAY+1 cycles before the next
   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         state   <= IDLE;
         idx     <= '0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
         cnt     <= '0;
         m_cyc_o <= 1'b0;
         m_stb_o <= 1'b0;
         m_dat_o <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  idx     <= '0;
                  done_q  <= 1'b0;
                  err_q   <= 1'b0;
                  m_dat_o <= tbl[0];
                  m_cyc_o <= 1'b1;
                  m_stb_o <= 1'b1;
                  state   <= WRITE;
               end
            end
            WRITE: begin
               if (m_err_i) begin
                  err_q   <= 1'b1;
                  m_cyc_o <= 1'b0;
                  m_stb_o <= 1'b0;
                  state   <= IDLE;
               end else if (m_ack_i) begin
                  m_cyc_o <= 1'b0;
                  m_stb_o <= 1'b0;
                  cnt     <= delay_q;
                  state   <= ctrl_en ? HOLD : IDLE;
               end
            end
            HOLD: begin
               if (!ctrl_en) begin
                  state <= IDLE;
               end else if (cnt != 16'd0) begin
                  cnt <= cnt - 16'd1;
               end else if (idx != ctrl_last) begin
                  idx     <= idx_nxt;
                  m_dat_o <= tbl[idx_nxt];
                  m_cyc_o <= 1'b1;
                  m_stb_o <= 1'b1;
                  state   <= WRITE;
               end else if (ctrl_loop) begin
                  idx     <= '0;
                  m_dat_o <= tbl[0];
                  m_cyc_o <= 1'b1;
                  m_stb_o <= 1'b1;
                  state   <= WRITE;
               end else begin
                  done_q <= 1'b1;
                  state  <= IDLE;
               end
            end
            default: begin
               state   <= IDLE;
               m_cyc_o <= 1'b0;
               m_stb_o <= 1'b0;
            end
         endcase
      end
   end

endmodule
